// File: rtl/hs_elastic_buffer.sv
// hs_elastic_buffer: req/ack elastic FIFO between an arf output port and a
// consumer, with transfer counters and a sticky overflow flag.
module hs_elastic_buffer #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int buffer_id  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        up_req,
    input  logic                        up_ack,
    input  logic [data_width-1:0]       up_din,
    input  logic                        dn_req,
    output logic                        dn_ack,
    output logic [data_width-1:0]       dn_dout,
    output logic [$clog2(depth):0]      occupancy,
    output logic [31:0]                 count_in,
    output logic [31:0]                 count_out,
    output logic                        overflow
);

    localparam int aw = $clog2(depth);
    localparam int ow = aw + 1;
    localparam logic [ow-1:0] full_lvl  = ow'(depth);
    localparam logic [ow-1:0] req_limit = ow'(depth - 2);

    // buffer_id only tags simulation diagnostics; nothing in hardware uses it
    logic unused_buffer_id;
    assign unused_buffer_id = (buffer_id == 0);

    logic [data_width-1:0] mem [depth];

    logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ow-1:0]         occ_q, occ_d;
    logic                  up_req_q, up_req_d;
    logic                  dn_ack_q, dn_ack_d;
    logic [data_width-1:0] dn_dout_q, dn_dout_d;
    logic [31:0]           count_in_q, count_in_d;
    logic [31:0]           count_out_q, count_out_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    always_comb begin
        // both decisions use pre-edge occupancy: a same-edge pop never
        // makes room for a push into a full buffer
        push        = up_ack && (occ_q != full_lvl);
        pop         = dn_req && !dn_ack_q && (occ_q != '0);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dn_ack_d    = 1'b0;
        dn_dout_d   = dn_dout_q;
        count_in_d  = count_in_q;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + aw'(1);
            count_in_d = count_in_q + 32'd1;
        end else if (up_ack) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            dn_ack_d    = 1'b1;
            dn_dout_d   = mem[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + aw'(1);
            count_out_d = count_out_q + 32'd1;
        end
        occ_d = occ_q + ow'(push) - ow'(pop);
        // keep two free slots so one late in-flight ack still fits
        up_req_d = (occ_d <= req_limit);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= up_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            up_req_q    <= 1'b0;
            dn_ack_q    <= 1'b0;
            dn_dout_q   <= '0;
            count_in_q  <= '0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            up_req_q    <= up_req_d;
            dn_ack_q    <= dn_ack_d;
            dn_dout_q   <= dn_dout_d;
            count_in_q  <= count_in_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign up_req    = up_req_q;
    assign dn_ack    = dn_ack_q;
    assign dn_dout   = dn_dout_q;
    assign occupancy = occ_q;
    assign count_in  = count_in_q;
    assign count_out = count_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_hs_elastic_buffer.sv
// Directed bench for hs_elastic_buffer (depth 4, 32-bit data).
module tb_hs_elastic_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        up_req;
    logic        up_ack = 1'b0;
    logic [31:0] up_din = '0;
    logic        dn_req = 1'b0;
    logic        dn_ack;
    logic [31:0] dn_dout;
    logic [2:0]  occupancy;
    logic [31:0] count_in;
    logic [31:0] count_out;
    logic        overflow;

    int total = 0;
    int bad = 0;

    hs_elastic_buffer #(.data_width(32), .depth(4), .buffer_id(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req(up_req), .up_ack(up_ack), .up_din(up_din),
        .dn_req(dn_req), .dn_ack(dn_ack), .dn_dout(dn_dout),
        .occupancy(occupancy), .count_in(count_in),
        .count_out(count_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int exp_v;
        int n;
        int val;
        logic prev;

        // reset held with up_ack active
        up_ack = 1'b1;
        up_din = 32'h55;
        dn_req = 1'b1;
        repeat (3) step();
        chk("rst_up_req", 32'(up_req), 0);
        chk("rst_dn_ack", 32'(dn_ack), 0);
        chk("rst_dout", dn_dout, 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_cin", count_in, 0);
        chk("rst_cout", count_out, 0);
        chk("rst_ovf", 32'(overflow), 0);
        up_ack = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rel_up_req", 32'(up_req), 1);

        // pass-through: push at t, delivered after t+1
        for (int i = 0; i < 100; i++) begin
            up_ack = 1'b1;
            up_din = 32'(i);
            step();
            up_ack = 1'b0;
            if (i == 0) begin
                chk("pt_occ1", 32'(occupancy), 1);
                chk("pt_noack", 32'(dn_ack), 0);
            end
            step();
            chk("pt_ack", 32'(dn_ack), 1);
            chk("pt_data", dn_dout, 32'(i));
        end
        step();
        chk("pt_ack_fall", 32'(dn_ack), 0);
        chk("pt_hold", dn_dout, 32'd99);
        chk("pt_cin", count_in, 100);
        chk("pt_cout", count_out, 100);
        chk("pt_ovf", 32'(overflow), 0);
        chk("pt_occ0", 32'(occupancy), 0);

        // fill with a compliant producer, consumer stalled
        dn_req = 1'b0;
        val = 10;
        prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            up_ack = up_req && !prev;
            up_din = 32'(val);
            if (up_ack) val++;
            prev = up_ack;
            step();
        end
        up_ack = 1'b0;
        chk("fill_occ", 32'(occupancy), 3);
        chk("fill_up_req", 32'(up_req), 0);
        chk("fill_next", 32'(val), 13);

        // drain and resume to 19
        dn_req = 1'b1;
        exp_v = 10;
        for (int c = 0; c < 200 && exp_v < 20; c++) begin
            up_ack = up_req && !prev && (val <= 19);
            up_din = 32'(val);
            if (up_ack) val++;
            prev = up_ack;
            step();
            if (dn_ack) begin
                chk("drain_data", dn_dout, 32'(exp_v));
                exp_v++;
            end
        end
        up_ack = 1'b0;
        chk("drain_all", 32'(exp_v), 20);
        step();
        chk("drain_occ", 32'(occupancy), 0);
        chk("drain_cin", count_in, 110);
        chk("drain_cout", count_out, 110);
        chk("drain_ovf", 32'(overflow), 0);

        // forced overflow ignoring up_req
        dn_req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            up_ack = 1'b1;
            up_din = 32'(i);
            step();
        end
        up_ack = 1'b0;
        chk("ovf_occ", 32'(occupancy), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_cin", count_in, 114);
        dn_req = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (dn_ack) begin
                n++;
                chk("ovf_data", dn_dout, 32'(n));
            end
        end
        chk("ovf_n", 32'(n), 4);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_cout", count_out, 114);

        // reset mid-transfer with a pending dn_ack
        dn_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_ack = 1'b1;
            up_din = 32'h21 + 32'(i);
            step();
        end
        up_ack = 1'b0;
        dn_req = 1'b1;
        step();
        chk("mid_ack", 32'(dn_ack), 1);
        chk("mid_data", dn_dout, 32'h21);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(dn_ack), 0);
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_cin", count_in, 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        step();
        dn_req = 1'b0;
        rst_n = 1'b1;
        step();
        chk("mid_rel_req", 32'(up_req), 1);

        // simultaneous push and pop at full
        for (int i = 0; i < 4; i++) begin
            up_ack = 1'b1;
            up_din = 32'h31 + 32'(i);
            step();
        end
        chk("sim_full", 32'(occupancy), 4);
        chk("sim_ovf0", 32'(overflow), 0);
        chk("sim_req0", 32'(up_req), 0);
        up_din = 32'hAA;
        dn_req = 1'b1;
        step();
        up_ack = 1'b0;
        chk("sim_ack", 32'(dn_ack), 1);
        chk("sim_data", dn_dout, 32'h31);
        chk("sim_occ", 32'(occupancy), 3);
        chk("sim_ovf", 32'(overflow), 1);
        chk("sim_cin", count_in, 4);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (dn_ack) begin
                chk("sim_drain", dn_dout, 32'h32 + 32'(n));
                n++;
            end
        end
        chk("sim_n", 32'(n), 3);
        chk("sim_cout", count_out, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_elastic_buffer.md
# hs_elastic_buffer

Elastic FIFO stage that sits directly downstream of an `arf` output port (`dout_req_N`/`dout_ack_N`/`dout_N`) and upstream of a `consumer`. It decouples the two req/ack handshakes and absorbs consumer stalls without back-pressuring the dataflow graph while space remains.

- Upstream side: the block acts as a consumer.
- Downstream side: the block acts as a producer.
- It also keeps transfer counters and a sticky overflow flag for throughput benches.

## Interface
Parameters:
- `data_width`, 32, payload width.
- `depth`, 4, number of FIFO entries. Must be a power of two, ≥ 2.
- `buffer_id`, 0, identifier printed in `$display` diagnostics only.

Ports:
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `up_req` output 1: request to the upstream producer (`arf` `dout_req_N`). Registered level.
- `up_ack` input 1: upstream data strobe. A one-cycle pulse; `up_din` is valid while it is high.
- `up_din` input `data_width`: upstream data.
- `dn_req` input 1: request from the downstream consumer.
- `dn_ack` output 1: downstream data strobe. Registered one-cycle pulse.
- `dn_dout` output `data_width`: downstream data. Registered; valid while `dn_ack`=1 and held afterwards.
- `occupancy` output `$clog2(depth)+1`: current number of stored entries.
- `count_in` output 32: total words accepted.
- `count_out` output 32: total words delivered.
- `overflow` output 1: sticky; set when a word is dropped.

## Operation
- Storage is a circular buffer `mem[depth]` with `wr_ptr`/`rd_ptr` of width `$clog2(depth)`. Pointers wrap naturally modulo `depth`.
- Push: on a rising edge with `up_ack`=1:
  - If `occupancy < depth`: `mem[wr_ptr] <= up_din`, `wr_ptr++`, `count_in++`.
  - Else the word is dropped, `overflow <= 1`, and `count_in` is unchanged.
- Pop: on a rising edge with `dn_req & ~dn_ack & (occupancy != 0)`: `dn_ack <= 1`, `dn_dout <= mem[rd_ptr]`, `rd_ptr++`, `count_out++`. Otherwise `dn_ack <= 0`.
  - The `~dn_ack` term guarantees at most one delivery every 2 cycles, matching the producer-protocol rule.
- Pop eligibility uses the pre-edge occupancy. A word pushed at edge t can first be popped at edge t+1.
- Simultaneous push and pop on the same edge:
  - Both are performed and `occupancy` is unchanged.
  - When full, a simultaneous pop does NOT free space for the same-edge push. The push is dropped and `overflow` is set.
- `occupancy_next` = `occupancy` + push − pop, where push and pop are the accepted operations only.
- `up_req` policy:
  - `up_req <= (depth − occupancy_next) >= 2`.
  - The 2-slot margin covers one in-flight `up_ack` that may arrive after `up_req` falls, because upstream answers a registered request one cycle late.
  - With a compliant upstream, `overflow` never sets.
- Counters wrap modulo 2^32 silently.
- No state machine beyond the FIFO. There are two modes, derived from `occupancy`:
  - EMPTY (0): no `dn_ack`.
  - FULL (`depth`): pushes dropped.

## Timing
- Reset (`rst_n`=0, asynchronous) forces all of these to 0 immediately and holds them while low:
  - `up_req`, `dn_ack`, `dn_dout`, `occupancy`, `count_in`, `count_out`, `overflow`, `wr_ptr`, `rd_ptr`.
  - `mem` contents are not reset.
- First edge after release: `up_req` rises (empty buffer, `depth` ≥ 2 free).
- Latency when empty: `up_ack` at edge t leads to `dn_ack`=1 with that word after edge t+1, provided `dn_req`=1 at t+1.
- Sustained throughput is 1 word per 2 cycles on each side, bounded by the `~dn_ack` and `~ack` protocol rules.
- `up_req` falls on the edge where free slots after update drop below 2. It rises on the edge where they return to ≥ 2.
- Reset asserted mid-transfer:
  - A pending `dn_ack` is cleared immediately.
  - Stored words are discarded (occupancy 0).
  - Counters restart at 0.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles with `up_ack`=1 → every output reads 0; `occupancy` stays 0; `up_req`=1 at the first edge after release.
- Pass-through: producer (`fail_rate` 0) sends 0..99 and the consumer always requests → consumer sees 0..99 in order; `count_in` = `count_out` = 100; `dn_ack` appears 1 cycle after each `up_ack` (first word); `overflow`=0.
- Fill and drain: `depth`=4, `dn_req`=0, producer sends 10..19 → `occupancy` stops at 3 or 4; `up_req`=0 once free < 2. Then raise `dn_req` → consumer receives 10,11,12,(13) in order, then the stream resumes with no gaps or duplicates.
- Forced overflow: `depth`=4, `dn_req`=0, drive `up_ack` pulses ignoring `up_req` with values 1..6 → `occupancy`=4; values 5 and 6 are dropped; `overflow`=1 and stays 1; draining yields 1,2,3,4 only.
- Simultaneous push/pop at full: `occupancy`=4 with pop eligible, `up_ack`=1 with 0xAA on the same edge → one word is delivered; 0xAA is dropped; `overflow`=1; `occupancy`=3.
- Bench integration: insert between `arf` `dout_4` and `consumer_4` with `fail_rate_consumer`=50, 5000 words → the output sequence equals the no-buffer run; `overflow`=0; throughput ≥ the no-buffer throughput.
